// File: rtl/piano_pkg.sv
// piano_pkg: shared note codes, LED patterns and ROM entry packing for the piano design
package piano_pkg;

    localparam int NOTE_W      = 4;
    localparam int ENTRY_DUR_W = 8;

    localparam logic [3:0] NOTE_C5   = 4'd0;
    localparam logic [3:0] NOTE_B    = 4'd1;
    localparam logic [3:0] NOTE_A    = 4'd2;
    localparam logic [3:0] NOTE_G    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_E    = 4'd5;
    localparam logic [3:0] NOTE_D    = 4'd6;
    localparam logic [3:0] NOTE_C4   = 4'd7;
    localparam logic [3:0] NOTE_NONE = 4'd8;
    localparam logic [3:0] NOTE_END  = 4'hF;

    localparam logic [7:0] LED_C5  = 8'h80;
    localparam logic [7:0] LED_B   = 8'h40;
    localparam logic [7:0] LED_A   = 8'h20;
    localparam logic [7:0] LED_G   = 8'h10;
    localparam logic [7:0] LED_F   = 8'h08;
    localparam logic [7:0] LED_E   = 8'h04;
    localparam logic [7:0] LED_D   = 8'h02;
    localparam logic [7:0] LED_C4  = 8'h01;
    localparam logic [7:0] LED_OFF = 8'h00;
    localparam logic [7:0] LED_BAD = 8'hFF;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_PAUSE} seq_state_t;

    // ROM entries are stored with a wide duration field; users truncate to their own width
    function automatic logic [NOTE_W+ENTRY_DUR_W-1:0] pack_entry(input logic [3:0] n, input logic [7:0] d);
        return {n, d};
    endfunction

    // Invalid codes light every LED so a corrupted table is obvious on the board
    function automatic logic [7:0] led_decode(input logic [3:0] n);
        case (n)
            NOTE_C5:   return LED_C5;
            NOTE_B:    return LED_B;
            NOTE_A:    return LED_A;
            NOTE_G:    return LED_G;
            NOTE_F:    return LED_F;
            NOTE_E:    return LED_E;
            NOTE_D:    return LED_D;
            NOTE_C4:   return LED_C4;
            NOTE_NONE: return LED_OFF;
            default:   return LED_BAD;
        endcase
    endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: combinational built-in song table, (song, step) -> {note, dur}
module song_rom import piano_pkg::*; #(
    parameter int SEL_W  = 2,
    parameter int STEP_W = 7,
    parameter int DUR_W  = 4
) (
    input  logic [SEL_W-1:0]  i_song,
    input  logic [STEP_W-1:0] i_step,
    output logic [3:0]        o_note,
    output logic [DUR_W-1:0]  o_dur
);

    logic [NOTE_W+ENTRY_DUR_W-1:0] w_entry;

    // Look up the entry; any song/step not listed reads back as an END marker
    always_comb begin
        w_entry = pack_entry(NOTE_END, 8'd0);
        case (int'(i_song))
            0: case (int'(i_step))
                0:  w_entry = pack_entry(NOTE_C4, 8'd1);
                1:  w_entry = pack_entry(NOTE_D,  8'd1);
                2:  w_entry = pack_entry(NOTE_E,  8'd1);
                3:  w_entry = pack_entry(NOTE_F,  8'd1);
                4:  w_entry = pack_entry(NOTE_G,  8'd1);
                5:  w_entry = pack_entry(NOTE_A,  8'd1);
                6:  w_entry = pack_entry(NOTE_B,  8'd1);
                7:  w_entry = pack_entry(NOTE_C5, 8'd1);
                8:  w_entry = pack_entry(NOTE_B,  8'd1);
                9:  w_entry = pack_entry(NOTE_A,  8'd1);
                10: w_entry = pack_entry(NOTE_G,  8'd1);
                11: w_entry = pack_entry(NOTE_F,  8'd1);
                12: w_entry = pack_entry(NOTE_E,  8'd1);
                13: w_entry = pack_entry(NOTE_D,  8'd1);
                14: w_entry = pack_entry(NOTE_C4, 8'd1);
                default: ;
            endcase
            1: case (int'(i_step))
                0: w_entry = pack_entry(NOTE_E, 8'd2);
                1: w_entry = pack_entry(NOTE_D, 8'd1);
                default: ;
            endcase
            2: case (int'(i_step))
                0: w_entry = pack_entry(NOTE_A,  8'd3);
                1: w_entry = pack_entry(NOTE_G,  8'd0);
                2: w_entry = pack_entry(NOTE_C5, 8'd2);
                default: ;
            endcase
            3: w_entry = pack_entry(4'(i_step) & 4'h7, 8'd1);
            default: ;
        endcase
    end

    assign o_note = w_entry[NOTE_W+ENTRY_DUR_W-1 -: NOTE_W];
    assign o_dur  = DUR_W'(w_entry[ENTRY_DUR_W-1:0]);

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: autoplay FSM stepping through ROM songs on beat ticks, driving note code and LEDs
module song_sequencer import piano_pkg::*; #(
    parameter int NUM_SONGS = 4,
    parameter int MAX_STEPS = 128,
    parameter int DUR_W     = 4,
    parameter int SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    parameter int STEP_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              QUARTER_BEAT,
    input  logic              START,
    input  logic              STOP,
    input  logic              PAUSE,
    input  logic              LOOP,
    input  logic [SEL_W-1:0]  SONG_SEL,
    output logic [3:0]        note,
    output logic [7:0]        Led,
    output logic              PLAYING,
    output logic              DONE,
    output logic [STEP_W-1:0] step
);

    seq_state_t        r_state;
    seq_state_t        w_state_n;
    logic [SEL_W-1:0]  r_song;
    logic [SEL_W-1:0]  w_song_n;
    logic [SEL_W-1:0]  w_sel;
    logic [SEL_W-1:0]  w_zero_song;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_n;
    logic [STEP_W:0]   w_next;
    logic [DUR_W-1:0]  r_rem;
    logic [DUR_W-1:0]  w_rem_n;
    logic [DUR_W-1:0]  w_next_dur;
    logic [DUR_W-1:0]  w_zero_dur;
    logic [DUR_W-1:0]  w_next_len;
    logic [DUR_W-1:0]  w_zero_len;
    logic [3:0]        r_cur;
    logic [3:0]        w_cur_n;
    logic [3:0]        w_next_note;
    logic [3:0]        w_zero_note;
    logic [3:0]        r_note;
    logic              r_playing;
    logic              r_done;
    logic              w_done_n;
    logic              w_end;

    // Out-of-range selections fall back to song 0
    assign w_sel       = (int'(SONG_SEL) >= NUM_SONGS) ? '0 : SONG_SEL;
    assign w_zero_song = START ? w_sel : r_song;
    assign w_next      = (STEP_W+1)'(r_step) + (STEP_W+1)'(1);
    assign w_next_len  = (w_next_dur == '0) ? DUR_W'(1) : w_next_dur;
    assign w_zero_len  = (w_zero_dur == '0) ? DUR_W'(1) : w_zero_dur;
    assign w_end       = (int'(w_next) == MAX_STEPS) || (w_next_note == NOTE_END);

    // Port for the entry after the current one
    song_rom #(.SEL_W(SEL_W), .STEP_W(STEP_W), .DUR_W(DUR_W)) u_rom_next (
        .i_song (r_song),
        .i_step (w_next[STEP_W-1:0]),
        .o_note (w_next_note),
        .o_dur  (w_next_dur)
    );

    // Port for entry 0, used on start and on loop-around
    song_rom #(.SEL_W(SEL_W), .STEP_W(STEP_W), .DUR_W(DUR_W)) u_rom_zero (
        .i_song (w_zero_song),
        .i_step ('0),
        .o_note (w_zero_note),
        .o_dur  (w_zero_dur)
    );

    // Next-state logic: STOP beats START beats PAUSE beats the beat tick
    always_comb begin
        w_state_n = r_state;
        w_song_n  = r_song;
        w_step_n  = r_step;
        w_rem_n   = r_rem;
        w_cur_n   = r_cur;
        w_done_n  = 1'b0;
        if (STOP) begin
            w_state_n = ST_IDLE;
            w_step_n  = '0;
            w_rem_n   = '0;
            w_cur_n   = NOTE_NONE;
        end else if (START) begin
            w_state_n = ST_PLAY;
            w_song_n  = w_sel;
            w_step_n  = '0;
            w_rem_n   = w_zero_len;
            w_cur_n   = w_zero_note;
        end else if (r_state == ST_PLAY) begin
            if (r_cur == NOTE_END || (QUARTER_BEAT && !PAUSE && r_rem <= DUR_W'(1) && w_end && !LOOP)) begin
                w_state_n = ST_IDLE;
                w_done_n  = 1'b1;
                w_step_n  = '0;
                w_rem_n   = '0;
                w_cur_n   = NOTE_NONE;
            end else if (PAUSE) begin
                w_state_n = ST_PAUSE;
            end else if (QUARTER_BEAT) begin
                w_rem_n  = (r_rem > DUR_W'(1)) ? r_rem - DUR_W'(1) : (w_end ? w_zero_len : w_next_len);
                w_step_n = (r_rem > DUR_W'(1)) ? r_step : (w_end ? '0 : w_next[STEP_W-1:0]);
                w_cur_n  = (r_rem > DUR_W'(1)) ? r_cur : (w_end ? w_zero_note : w_next_note);
            end
        end else if (r_state == ST_PAUSE && !PAUSE) begin
            w_state_n = ST_PLAY;
        end
    end

    // State and registered outputs; note is silenced outside PLAY and on an END entry
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_song    <= '0;
            r_step    <= '0;
            r_rem     <= '0;
            r_cur     <= NOTE_NONE;
            r_note    <= NOTE_NONE;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_song    <= w_song_n;
            r_step    <= w_step_n;
            r_rem     <= w_rem_n;
            r_cur     <= w_cur_n;
            r_note    <= (w_state_n == ST_PLAY && w_cur_n != NOTE_END) ? w_cur_n : NOTE_NONE;
            r_playing <= w_state_n != ST_IDLE;
            r_done    <= w_done_n;
        end
    end

    assign note    = r_note;
    assign Led     = led_decode(r_note);
    assign PLAYING = r_playing;
    assign DONE    = r_done;
    assign step    = r_step;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed stimulus with a song-level reference model checked every cycle
module tb_song_sequencer;

    localparam int NS = 5;
    localparam int MS = 20;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       QUARTER_BEAT = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       PAUSE = 1'b0;
    logic       LOOP = 1'b0;
    logic [2:0] SONG_SEL = 3'd0;
    logic [3:0] note;
    logic [7:0] Led;
    logic       PLAYING;
    logic       DONE;
    logic [4:0] step;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    int s_note [NS][MS];
    int s_dur  [NS][MS];
    int c_major [15] = '{7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7};

    int m_state = 0;
    int m_song = 0;
    int m_step = 0;
    int m_left = 0;
    int m_done = 0;

    song_sequencer #(.NUM_SONGS(NS), .MAX_STEPS(MS), .DUR_W(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .QUARTER_BEAT (QUARTER_BEAT),
        .START        (START),
        .STOP         (STOP),
        .PAUSE        (PAUSE),
        .LOOP         (LOOP),
        .SONG_SEL     (SONG_SEL),
        .note         (note),
        .Led          (Led),
        .PLAYING      (PLAYING),
        .DONE         (DONE),
        .step         (step)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int led_exp(input int n);
        case (n)
            0: return 8'h80;
            1: return 8'h40;
            2: return 8'h20;
            3: return 8'h10;
            4: return 8'h08;
            5: return 8'h04;
            6: return 8'h02;
            7: return 8'h01;
            8: return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int exp_note();
        return (m_state == 1 && s_note[m_song][m_step] != 15) ? s_note[m_song][m_step] : 8;
    endfunction

    task automatic song_end();
        m_state = 0;
        m_done = 1;
        m_step = 0;
    endtask

    // Song-level model: a note plays for its tick count, then the song moves on, loops or ends
    task automatic model_step();
        int nx;
        m_done = 0;
        if (RESET || STOP) begin
            m_state = 0;
            m_step = 0;
        end else if (START) begin
            m_state = 1;
            m_song = (int'(SONG_SEL) < NS) ? int'(SONG_SEL) : 0;
            m_step = 0;
            m_left = eff(s_dur[m_song][0]);
        end else if (m_state == 1) begin
            if (s_note[m_song][m_step] == 15) song_end();
            else if (PAUSE) m_state = 2;
            else if (QUARTER_BEAT) begin
                m_left--;
                if (m_left == 0) begin
                    nx = m_step + 1;
                    if (nx == MS || s_note[m_song][nx] == 15) begin
                        if (LOOP) begin
                            m_step = 0;
                            m_left = eff(s_dur[m_song][0]);
                        end else song_end();
                    end else begin
                        m_step = nx;
                        m_left = eff(s_dur[m_song][nx]);
                    end
                end
            end
        end else if (m_state == 2 && !PAUSE) m_state = 1;
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Every cycle after reset, compare all outputs against the model
    initial forever begin
        @(negedge CLK);
        if (armed) begin
            chk("cyc_note", int'(note), exp_note());
            chk("cyc_led", int'(Led), led_exp(exp_note()));
            chk("cyc_playing", int'(PLAYING), (m_state != 0) ? 1 : 0);
            chk("cyc_done", int'(DONE), m_done);
            chk("cyc_step", int'(step), m_step);
        end
    end

    task automatic tk();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tk();
    endtask

    task automatic beat();
        QUARTER_BEAT = 1'b1;
        tk();
        QUARTER_BEAT = 1'b0;
    endtask

    task automatic go(input int sel);
        SONG_SEL = 3'(sel);
        START = 1'b1;
        tk();
        START = 1'b0;
    endtask

    task automatic stop_now();
        STOP = 1'b1;
        tk();
        STOP = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < MS; i++) begin
                s_note[s][i] = 15;
                s_dur[s][i] = 0;
            end
        for (int i = 0; i < 15; i++) begin
            s_note[0][i] = c_major[i];
            s_dur[0][i] = 1;
        end
        s_note[1][0] = 5; s_dur[1][0] = 2;
        s_note[1][1] = 6; s_dur[1][1] = 1;
        s_note[2][0] = 2; s_dur[2][0] = 3;
        s_note[2][1] = 3; s_dur[2][1] = 0;
        s_note[2][2] = 0; s_dur[2][2] = 2;
        for (int i = 0; i < MS; i++) begin
            s_note[3][i] = i % 8;
            s_dur[3][i] = 1;
        end

        idle(3);
        RESET = 1'b0;
        armed = 1'b1;
        tk();
        chk("rst_note", int'(note), 8);
        chk("rst_led", int'(Led), 0);
        chk("rst_playing", int'(PLAYING), 0);
        chk("rst_step", int'(step), 0);

        go(0);
        repeat (5) beat();
        chk("mid_step", int'(step), 5);
        chk("mid_note", int'(note), 2);
        RESET = 1'b1;
        tk();
        RESET = 1'b0;
        chk("rstmid_note", int'(note), 8);
        chk("rstmid_led", int'(Led), 0);
        chk("rstmid_step", int'(step), 0);
        chk("rstmid_playing", int'(PLAYING), 0);

        LOOP = 1'b0;
        go(1);
        chk("s1_start_note", int'(note), 5);
        chk("s1_start_playing", int'(PLAYING), 1);
        idle(3); beat();
        chk("s1_tick1_note", int'(note), 5);
        idle(3); beat();
        chk("s1_tick2_note", int'(note), 6);
        chk("s1_tick2_step", int'(step), 1);
        idle(3); beat();
        chk("s1_done", int'(DONE), 1);
        chk("s1_end_note", int'(note), 8);
        chk("s1_end_playing", int'(PLAYING), 0);
        tk();
        chk("s1_done_once", int'(DONE), 0);

        LOOP = 1'b1;
        go(1);
        for (int k = 0; k < 3; k++) begin
            idle(3); beat();
            idle(3); beat();
            chk("loop_d_note", int'(note), 6);
            idle(3); beat();
            chk("loop_step", int'(step), 0);
            chk("loop_note", int'(note), 5);
            chk("loop_no_done", int'(DONE), 0);
        end
        LOOP = 1'b0;
        stop_now();
        chk("stop_no_done", int'(DONE), 0);
        chk("stop_playing", int'(PLAYING), 0);

        SONG_SEL = 3'd1;
        START = 1'b1;
        QUARTER_BEAT = 1'b1;
        tk();
        START = 1'b0;
        QUARTER_BEAT = 1'b0;
        beat();
        chk("sq_first_note", int'(note), 5);
        beat();
        chk("sq_second_note", int'(note), 6);

        START = 1'b1;
        STOP = 1'b1;
        tk();
        START = 1'b0;
        STOP = 1'b0;
        chk("ss_playing", int'(PLAYING), 0);
        chk("ss_done", int'(DONE), 0);
        chk("ss_note", int'(note), 8);

        go(1);
        PAUSE = 1'b1;
        tk();
        chk("pz_paused_note", int'(note), 8);
        SONG_SEL = 3'd2;
        START = 1'b1;
        tk();
        START = 1'b0;
        PAUSE = 1'b0;
        chk("pz_restart_note", int'(note), 2);
        chk("pz_restart_step", int'(step), 0);
        chk("pz_restart_playing", int'(PLAYING), 1);
        stop_now();

        go(2);
        beat();
        PAUSE = 1'b1;
        tk();
        chk("pa_note", int'(note), 8);
        chk("pa_playing", int'(PLAYING), 1);
        repeat (10) begin
            beat();
            chk("pa_hold_note", int'(note), 8);
        end
        PAUSE = 1'b0;
        tk();
        chk("pa_resume_note", int'(note), 2);
        beat();
        chk("pa_a_second", int'(note), 2);
        beat();
        chk("pa_g_note", int'(note), 3);
        chk("pa_g_step", int'(step), 1);
        beat();
        chk("pa_dur0_note", int'(note), 0);
        chk("pa_dur0_step", int'(step), 2);
        beat();
        beat();
        chk("pa_done", int'(DONE), 1);

        go(5);
        chk("sel_oob_note", int'(note), 7);
        beat();
        chk("sel_oob_next", int'(note), 6);
        stop_now();

        go(4);
        chk("empty_playing", int'(PLAYING), 1);
        chk("empty_note", int'(note), 8);
        tk();
        chk("empty_playing_fall", int'(PLAYING), 0);
        chk("empty_done", int'(DONE), 1);

        go(3);
        QUARTER_BEAT = 1'b1;
        idle(MS - 1);
        chk("full_last_step", int'(step), MS - 1);
        chk("full_last_note", int'(note), 3);
        tk();
        QUARTER_BEAT = 1'b0;
        chk("full_done", int'(DONE), 1);
        chk("full_playing", int'(PLAYING), 0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
